// File: rtl/bitset_reg_pkg.sv
// bitset_reg_pkg
//   Shared definitions for the bitset register slice: command opcodes,
//   scan FSM states and parameter limits. Imported by nbit_bitset and
//   bitset_reg.
package bitset_reg_pkg;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 256;

    typedef enum logic [2:0] {
        OP_NOP      = 3'b000,
        OP_WRITE    = 3'b001,
        OP_SET      = 3'b010,
        OP_CLEAR    = 3'b011,
        OP_TOGGLE   = 3'b100,
        OP_LOAD_ALL = 3'b101,
        OP_SCAN     = 3'b110,
        OP_RSVD     = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/nbit_bitset.sv
// nbit_bitset
//   Combinational next-word generator for single-bit edits and whole-word
//   load. Opcodes other than WRITE/SET/CLEAR/TOGGLE/LOAD_ALL pass x through.
//   A bit index >= WIDTH leaves the word unchanged (LOAD_ALL ignores index).
// Ports:
//   x     : current word
//   index : target bit
//   value : bit value for WRITE, fill value for LOAD_ALL
//   op    : 3-bit opcode
//   y     : next word
module nbit_bitset
    import bitset_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = 3
) (
    input  logic [WIDTH-1:0] x,
    input  logic [IDXW-1:0]  index,
    input  logic             value,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);

    localparam logic [IDXW:0] WIDTH_X = (IDXW+1)'(WIDTH);

    logic             in_range;
    logic [WIDTH-1:0] onehot;
    op_e              opc;

    assign opc      = op_e'(op);
    assign in_range = ({1'b0, index} < WIDTH_X);
    // An empty mask turns every single-bit edit into a no-op when out of range.
    assign onehot   = in_range ? (WIDTH'(1) << index) : '0;

    always_comb begin
        y = x;
        unique case (opc)
            OP_WRITE:    y = value ? (x | onehot) : (x & ~onehot);
            OP_SET:      y = x | onehot;
            OP_CLEAR:    y = x & ~onehot;
            OP_TOGGLE:   y = x ^ onehot;
            OP_LOAD_ALL: y = {WIDTH{value}};
            default:     y = x;
        endcase
    end

endmodule

// File: rtl/bitset_reg.sv
// bitset_reg
//   Registered WIDTH-bit bitset with single-bit edits, whole-word load and
//   a one-bit-per-cycle scan for the first bit equal to a match value.
//   Commands use valid/ready; scan results return on a one-cycle pulse.
// Configuration:
//   BITSET_REG_SCAN_WRAP_EN - when defined, a scan wraps from WIDTH-1 to 0
//   and stops after WIDTH positions; an out-of-range start begins at 0.
//   When undefined, a scan stops at WIDTH-1 and an out-of-range start
//   reports a miss immediately.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake
//   cmd_op              : opcode
//   cmd_index           : target bit or scan start
//   cmd_value           : write/fill value or scan match value
//   bits                : current contents
//   rsp_valid           : one-cycle scan result pulse
//   rsp_found/rsp_index : scan result, held until the next response
module bitset_reg
    import bitset_reg_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter int unsigned      IDXW  = 3,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [IDXW-1:0]  cmd_index,
    input  logic             cmd_value,
    output logic [WIDTH-1:0] bits,
    output logic             rsp_valid,
    output logic             rsp_found,
    output logic [IDXW-1:0]  rsp_index
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || (2**IDXW) < WIDTH) begin : g_bad_params
        $error("bitset_reg: illegal WIDTH/IDXW combination");
    end

    localparam logic [IDXW:0]   WIDTH_X = (IDXW+1)'(WIDTH);
    localparam logic [IDXW-1:0] LAST    = IDXW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [IDXW-1:0]  ptr_q, ptr_d;
    logic             match_q, match_d;
    logic [WIDTH-1:0] bits_q, bits_d;
    logic [WIDTH-1:0] edit_y;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_found_q, rsp_found_d;
    logic [IDXW-1:0]  rsp_index_q, rsp_index_d;
    logic             accept;
    logic             start_in_range;
    logic             cur_bit;
    logic             scan_done;
    logic [IDXW-1:0]  next_ptr;
`ifdef BITSET_REG_SCAN_WRAP_EN
    logic [IDXW-1:0]  cnt_q, cnt_d;
`endif

    nbit_bitset #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_edit (
        .x     (bits_q),
        .index (cmd_index),
        .value (cmd_value),
        .op    (cmd_op),
        .y     (edit_y)
    );

    assign cmd_ready      = (state_q == ST_IDLE) & ~reset;
    assign accept         = cmd_valid & cmd_ready;
    assign start_in_range = ({1'b0, cmd_index} < WIDTH_X);
    // Masked reduction keeps every bit of the word in use while selecting bits_q[ptr_q].
    assign cur_bit        = |(bits_q & (WIDTH'(1) << ptr_q));

`ifdef BITSET_REG_SCAN_WRAP_EN
    assign scan_done = (cnt_q == LAST);
    assign next_ptr  = (ptr_q == LAST) ? '0 : ptr_q + IDXW'(1);
`else
    assign scan_done = (ptr_q == LAST);
    assign next_ptr  = ptr_q + IDXW'(1);
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        match_d     = match_q;
        bits_d      = bits_q;
        rsp_valid_d = 1'b0;
        rsp_found_d = rsp_found_q;
        rsp_index_d = rsp_index_q;
`ifdef BITSET_REG_SCAN_WRAP_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    // Non-edit opcodes come back from nbit_bitset unchanged.
                    bits_d = edit_y;
                    if (op_e'(cmd_op) == OP_SCAN) begin
                        match_d = cmd_value;
`ifdef BITSET_REG_SCAN_WRAP_EN
                        ptr_d   = start_in_range ? cmd_index : '0;
                        cnt_d   = '0;
                        state_d = ST_SCAN;
`else
                        if (start_in_range) begin
                            ptr_d   = cmd_index;
                            state_d = ST_SCAN;
                        end else begin
                            rsp_valid_d = 1'b1;
                            rsp_found_d = 1'b0;
                            rsp_index_d = '0;
                        end
`endif
                    end
                end
            end
            ST_SCAN: begin
                if (cur_bit == match_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_found_d = 1'b1;
                    rsp_index_d = ptr_q;
                    state_d     = ST_IDLE;
                end else if (scan_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_found_d = 1'b0;
                    rsp_index_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    ptr_d = next_ptr;
`ifdef BITSET_REG_SCAN_WRAP_EN
                    cnt_d = cnt_q + IDXW'(1);
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            match_q     <= 1'b0;
            bits_q      <= INIT;
            rsp_valid_q <= 1'b0;
            rsp_found_q <= 1'b0;
            rsp_index_q <= '0;
`ifdef BITSET_REG_SCAN_WRAP_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            match_q     <= match_d;
            bits_q      <= bits_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_found_q <= rsp_found_d;
            rsp_index_q <= rsp_index_d;
`ifdef BITSET_REG_SCAN_WRAP_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bits      = bits_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_found = rsp_found_q;
    assign rsp_index = rsp_index_q;

endmodule
